// File: rtl/uart_rx_frame_seq_if.sv
// UART receive frame sequencer bus.
// Groups the line-side inputs (enable, oversample tick, synchronised RX line)
// and the frame results that go to the receive controller.
//   master : the side that drives en / baud_tick_rx / rx_in and consumes results
//   slave  : the frame sequencer itself
// DATA_BITS must match the sequencer's DATA_BITS (width of data_out).
interface uart_rx_frame_seq_if #(
    parameter int DATA_BITS = 8
);
    logic                 en;
    logic                 baud_tick_rx;
    logic                 rx_in;
    logic                 busy;
    logic                 sample;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] data_out;
    logic                 done_rx;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output en, baud_tick_rx, rx_in,
        input  busy, sample, bit_idx, data_out, done_rx, frame_err, parity_err
    );

    modport slave (
        input  en, baud_tick_rx, rx_in,
        output busy, sample, bit_idx, data_out, done_rx, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_frame_seq.sv
// uart_rx_frame_seq
// Tracks one serial frame (start, data, optional parity, stop bits) on an
// oversampled baud tick, samples each bit at its centre, assembles the data
// word LSB first and flags framing / parity errors. One done_rx pulse is
// produced per completed frame.
// Ports:
//   clk  - single clock
//   rst  - asynchronous active-high reset
//   bus  - uart_rx_frame_seq_if.slave:
//          en, baud_tick_rx, rx_in           (inputs)
//          busy, sample, bit_idx, data_out,
//          done_rx, frame_err, parity_err    (registered outputs)
module uart_rx_frame_seq #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_frame_seq_if.slave   bus
);

    localparam int TCW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [TCW-1:0] TC_HALF   = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_FULL   = TCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           HAS_PAR   = (PARITY_EN != 0);
    localparam logic           ODD_PAR   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Non-zero when data word, received parity bit and parity sense disagree.
    function automatic logic parity_mismatch(
        input logic [DATA_BITS-1:0] word,
        input logic                 pbit
    );
        return (^word) ^ pbit ^ ODD_PAR;
    endfunction

    state_t               state_r,     state_s;
    logic [TCW-1:0]       tcnt_r,      tcnt_s;
    logic [3:0]           bcnt_r,      bcnt_s;      // data bit or stop bit count
    logic [DATA_BITS-1:0] shift_r,     shift_s;
    logic                 pend_ferr_r, pend_ferr_s;
    logic                 pend_perr_r, pend_perr_s;

    logic                 busy_r,      busy_s;
    logic                 sample_r,    sample_s;
    logic [3:0]           bit_idx_r,   bit_idx_s;
    logic [DATA_BITS-1:0] data_out_r,  data_out_s;
    logic                 done_r,      done_s;
    logic                 ferr_r,      ferr_s;
    logic                 perr_r,      perr_s;

    logic                 mid_bit_s;

    // Next-state, counter, shift register and output-next logic.
    always_comb begin
        state_s     = state_r;
        tcnt_s      = tcnt_r;
        bcnt_s      = bcnt_r;
        shift_s     = shift_r;
        pend_ferr_s = pend_ferr_r;
        pend_perr_s = pend_perr_r;
        sample_s    = 1'b0;
        done_s      = 1'b0;
        bit_idx_s   = bit_idx_r;
        data_out_s  = data_out_r;
        ferr_s      = ferr_r;
        perr_s      = perr_r;
        mid_bit_s   = (tcnt_r == TC_FULL);

        if (!bus.en) begin
            // Enable low wins over any tick; results of the last frame stay.
            state_s     = S_IDLE;
            tcnt_s      = {TCW{1'b0}};
            bcnt_s      = 4'd0;
            pend_ferr_s = 1'b0;
            pend_perr_s = 1'b0;
        end else if (bus.baud_tick_rx) begin
            case (state_r)
                S_IDLE: begin
                    if (!bus.rx_in) begin
                        state_s     = S_START;
                        tcnt_s      = {TCW{1'b0}};
                        bcnt_s      = 4'd0;
                        pend_ferr_s = 1'b0;
                        pend_perr_s = 1'b0;
                    end else begin
                        state_s = S_IDLE;
                    end
                end

                S_START: begin
                    if (tcnt_r == TC_HALF) begin
                        // Centre of the start bit: a high line means a glitch.
                        tcnt_s  = {TCW{1'b0}};
                        state_s = bus.rx_in ? S_IDLE : S_DATA;
                    end else begin
                        tcnt_s = tcnt_r + {{(TCW-1){1'b0}}, 1'b1};
                    end
                end

                S_DATA: begin
                    if (mid_bit_s) begin
                        tcnt_s    = {TCW{1'b0}};
                        shift_s   = {bus.rx_in, shift_r[DATA_BITS-1:1]};
                        sample_s  = 1'b1;
                        bit_idx_s = bcnt_r;
                        if (bcnt_r == DATA_LAST) begin
                            bcnt_s  = 4'd0;
                            state_s = HAS_PAR ? S_PARITY : S_STOP;
                        end else begin
                            bcnt_s = bcnt_r + 4'd1;
                        end
                    end else begin
                        tcnt_s = tcnt_r + {{(TCW-1){1'b0}}, 1'b1};
                    end
                end

                S_PARITY: begin
                    if (mid_bit_s) begin
                        tcnt_s      = {TCW{1'b0}};
                        sample_s    = 1'b1;
                        pend_perr_s = parity_mismatch(shift_r, bus.rx_in);
                        bcnt_s      = 4'd0;
                        state_s     = S_STOP;
                    end else begin
                        tcnt_s = tcnt_r + {{(TCW-1){1'b0}}, 1'b1};
                    end
                end

                S_STOP: begin
                    if (mid_bit_s) begin
                        tcnt_s   = {TCW{1'b0}};
                        sample_s = 1'b1;
                        if (bcnt_r == STOP_LAST) begin
                            // Last stop sample: publish the frame.
                            data_out_s  = shift_r;
                            ferr_s      = pend_ferr_r | ~bus.rx_in;
                            perr_s      = pend_perr_r;
                            done_s      = 1'b1;
                            bcnt_s      = 4'd0;
                            pend_ferr_s = 1'b0;
                            pend_perr_s = 1'b0;
                            state_s     = S_IDLE;
                        end else begin
                            pend_ferr_s = pend_ferr_r | ~bus.rx_in;
                            bcnt_s      = bcnt_r + 4'd1;
                        end
                    end else begin
                        tcnt_s = tcnt_r + {{(TCW-1){1'b0}}, 1'b1};
                    end
                end

                default: begin
                    state_s     = S_IDLE;
                    tcnt_s      = {TCW{1'b0}};
                    bcnt_s      = 4'd0;
                    pend_ferr_s = 1'b0;
                    pend_perr_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        busy_s = (state_s != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            tcnt_r      <= {TCW{1'b0}};
            bcnt_r      <= 4'd0;
            shift_r     <= {DATA_BITS{1'b0}};
            pend_ferr_r <= 1'b0;
            pend_perr_r <= 1'b0;
            busy_r      <= 1'b0;
            sample_r    <= 1'b0;
            bit_idx_r   <= 4'd0;
            data_out_r  <= {DATA_BITS{1'b0}};
            done_r      <= 1'b0;
            ferr_r      <= 1'b0;
            perr_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            tcnt_r      <= tcnt_s;
            bcnt_r      <= bcnt_s;
            shift_r     <= shift_s;
            pend_ferr_r <= pend_ferr_s;
            pend_perr_r <= pend_perr_s;
            busy_r      <= busy_s;
            sample_r    <= sample_s;
            bit_idx_r   <= bit_idx_s;
            data_out_r  <= data_out_s;
            done_r      <= done_s;
            ferr_r      <= ferr_s;
            perr_r      <= perr_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.sample     = sample_r;
    assign bus.bit_idx    = bit_idx_r;
    assign bus.data_out   = data_out_r;
    assign bus.done_rx    = done_r;
    assign bus.frame_err  = ferr_r;
    assign bus.parity_err = perr_r;

endmodule

// File: tb/tb_uart_rx_frame_seq.sv
// Testbench for uart_rx_frame_seq.
// Three sequencer instances share clk, rst and the oversample tick:
//   dut0: 8 data, no parity, 1 stop
//   dut1: 8 data, even parity, 1 stop
//   dut2: 7 data, no parity, 2 stop
// Frames are built bit by bit on each instance's RX line; expected word,
// error flags, sample count and done latency come from a frame-level model.
module tb_uart_rx_frame_seq;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud = 1'b0;
    logic en_line [3];
    logic rx_line [3];

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt = 0;
    int done_cnt  [3] = '{0, 0, 0};
    int samp_cnt  [3] = '{0, 0, 0};
    int done_tick [3] = '{0, 0, 0};

    logic [31:0] exp_dout [3] = '{32'd0, 32'd0, 32'd0};
    logic        exp_ferr [3] = '{1'b0, 1'b0, 1'b0};
    logic        exp_perr [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    uart_rx_frame_seq_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_frame_seq_if #(.DATA_BITS(8)) bus1 ();
    uart_rx_frame_seq_if #(.DATA_BITS(7)) bus2 ();

    assign bus0.en = en_line[0];
    assign bus1.en = en_line[1];
    assign bus2.en = en_line[2];
    assign bus0.rx_in = rx_line[0];
    assign bus1.rx_in = rx_line[1];
    assign bus2.rx_in = rx_line[2];
    assign bus0.baud_tick_rx = baud;
    assign bus1.baud_tick_rx = baud;
    assign bus2.baud_tick_rx = baud;

    uart_rx_frame_seq #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0),
                        .PARITY_ODD(0), .STOP_BITS(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_rx_frame_seq #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1),
                        .PARITY_ODD(0), .STOP_BITS(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_rx_frame_seq #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_EN(0),
                        .PARITY_ODD(0), .STOP_BITS(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_dout(input int sel);
        case (sel)
            0:       return 32'(bus0.data_out);
            1:       return 32'(bus1.data_out);
            default: return 32'(bus2.data_out);
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return bus0.busy;
            1:       return bus1.busy;
            default: return bus2.busy;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return bus0.done_rx;
            1:       return bus1.done_rx;
            default: return bus2.done_rx;
        endcase
    endfunction

    function automatic logic get_sample(input int sel);
        case (sel)
            0:       return bus0.sample;
            1:       return bus1.sample;
            default: return bus2.sample;
        endcase
    endfunction

    function automatic logic get_ferr(input int sel);
        case (sel)
            0:       return bus0.frame_err;
            1:       return bus1.frame_err;
            default: return bus2.frame_err;
        endcase
    endfunction

    function automatic logic get_perr(input int sel);
        case (sel)
            0:       return bus0.parity_err;
            1:       return bus1.parity_err;
            default: return bus2.parity_err;
        endcase
    endfunction

    function automatic logic [3:0] get_bidx(input int sel);
        case (sel)
            0:       return bus0.bit_idx;
            1:       return bus1.bit_idx;
            default: return bus2.bit_idx;
        endcase
    endfunction

    // Pulse counters; done must coincide with a sample and with busy dropping.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (get_sample(i)) samp_cnt[i]++;
                if (get_done(i)) begin
                    done_cnt[i]++;
                    done_tick[i] = tick_cnt;
                    check_eq("busy_low_at_done", 32'(get_busy(i)), 32'd0);
                    check_eq("sample_at_done", 32'(get_sample(i)), 32'd1);
                end
            end
        end
    end

    // One oversample tick, followed by a random idle gap.
    task automatic do_tick();
        int gap;
        gap = $urandom_range(0, 2);
        @(negedge clk);
        baud = 1'b1;
        tick_cnt++;
        @(negedge clk);
        baud = 1'b0;
        repeat (gap) @(negedge clk);
        #1;
    endtask

    // Send one frame on instance sel; abort_bit >= 0 drops en mid-bit instead.
    task automatic send_frame(input int sel, input int data, input int nd, input bit pe,
                              input bit pbit, input int nstop, input bit [1:0] stopv,
                              input int abort_bit);
        bit   bits[$];
        int   det, d0, s0, ones, nb;
        logic [31:0] mask, dv;
        bit   ferr, perr;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(((data >> i) & 1) != 0);
        if (pe) bits.push_back(pbit);
        for (int i = 0; i < nstop; i++) bits.push_back(stopv[i]);
        det = 0;
        d0 = done_cnt[sel];
        s0 = samp_cnt[sel];
        for (int b = 0; b < bits.size(); b++) begin
            rx_line[sel] = bits[b];
            for (int t = 0; t < OS; t++) begin
                if (b == abort_bit && t == 5) begin
                    check_eq("busy_before_drop", 32'(get_busy(sel)), 32'd1);
                    @(negedge clk);
                    en_line[sel] = 1'b0;
                    @(negedge clk);
                    #1;
                    check_eq("busy_after_en_drop", 32'(get_busy(sel)), 32'd0);
                    en_line[sel] = 1'b1;
                    rx_line[sel] = 1'b1;
                    repeat (3 * OS) do_tick();
                    check_eq("no_done_after_abort", 32'(done_cnt[sel] - d0), 32'd0);
                    check_eq("dout_kept_after_abort", get_dout(sel), exp_dout[sel]);
                    check_eq("ferr_kept_after_abort", 32'(get_ferr(sel)), 32'(exp_ferr[sel]));
                    return;
                end
                do_tick();
                if (b == 0 && t == 0) det = tick_cnt;
            end
        end
        rx_line[sel] = 1'b1;
        repeat (2) do_tick();

        // Frame-level model.
        nb   = bits.size() - 1;
        mask = (32'd1 << nd) - 32'd1;
        dv   = 32'(data) & mask;
        ones = 0;
        for (int i = 0; i < nd; i++) ones += int'(dv[i]);
        ferr = 1'b0;
        for (int i = 0; i < nstop; i++) if (!stopv[i]) ferr = 1'b1;
        perr = pe && (((ones + int'(pbit)) % 2) != 0);
        exp_dout[sel] = dv;
        exp_ferr[sel] = ferr;
        exp_perr[sel] = perr;

        check_eq($sformatf("done_count_d%0d", sel), 32'(done_cnt[sel] - d0), 32'd1);
        check_eq($sformatf("latency_d%0d", sel), 32'(done_tick[sel] - det), 32'(OS / 2 + nb * OS));
        check_eq($sformatf("samples_d%0d", sel), 32'(samp_cnt[sel] - s0), 32'(nb));
        check_eq($sformatf("data_d%0d", sel), get_dout(sel), exp_dout[sel]);
        check_eq($sformatf("ferr_d%0d", sel), 32'(get_ferr(sel)), 32'(exp_ferr[sel]));
        check_eq($sformatf("perr_d%0d", sel), 32'(get_perr(sel)), 32'(exp_perr[sel]));
        check_eq($sformatf("bit_idx_d%0d", sel), 32'(get_bidx(sel)), 32'(nd - 1));
        check_eq($sformatf("idle_after_d%0d", sel), 32'(get_busy(sel)), 32'd0);
    endtask

    task automatic check_reset_vals(input int sel);
        check_eq("rst_busy", 32'(get_busy(sel)), 32'd0);
        check_eq("rst_sample", 32'(get_sample(sel)), 32'd0);
        check_eq("rst_bit_idx", 32'(get_bidx(sel)), 32'd0);
        check_eq("rst_data", get_dout(sel), 32'd0);
        check_eq("rst_done", 32'(get_done(sel)), 32'd0);
        check_eq("rst_ferr", 32'(get_ferr(sel)), 32'd0);
        check_eq("rst_perr", 32'(get_perr(sel)), 32'd0);
    endtask

    initial begin
        int d0, s0, sel, data;
        bit pbit;
        bit [1:0] stopv;
        for (int i = 0; i < 3; i++) begin
            en_line[i] = 1'b1;
            rx_line[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset_vals(i);
        rst = 1'b0;
        repeat (4) do_tick();

        // 8N1 0xA5.
        send_frame(0, 32'hA5, 8, 1'b0, 1'b0, 1, 2'b11, -1);

        // 4-tick low glitch: false start rejected at the start-bit centre.
        d0 = done_cnt[0];
        s0 = samp_cnt[0];
        rx_line[0] = 1'b0;
        repeat (4) do_tick();
        rx_line[0] = 1'b1;
        repeat (4) do_tick();
        check_eq("glitch_busy_mid", 32'(get_busy(0)), 32'd1);
        do_tick();
        check_eq("glitch_busy_end", 32'(get_busy(0)), 32'd0);
        repeat (4) do_tick();
        check_eq("glitch_no_sample", 32'(samp_cnt[0] - s0), 32'd0);
        check_eq("glitch_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check_eq("glitch_data_kept", get_dout(0), exp_dout[0]);

        // Low stop bit then a clean frame.
        send_frame(0, 32'h3C, 8, 1'b0, 1'b0, 1, 2'b00, -1);
        send_frame(0, 32'h00, 8, 1'b0, 1'b0, 1, 2'b11, -1);

        // Even parity on 0x07: bit 0 is wrong, bit 1 is right.
        send_frame(1, 32'h07, 8, 1'b1, 1'b0, 1, 2'b11, -1);
        send_frame(1, 32'h07, 8, 1'b1, 1'b1, 1, 2'b11, -1);

        // en dropped during data bit 4, then 0x5A.
        send_frame(0, 32'hFF, 8, 1'b0, 1'b0, 1, 2'b11, 5);
        send_frame(0, 32'h5A, 8, 1'b0, 1'b0, 1, 2'b11, -1);

        // Randomised frames on all instances.
        for (int r = 0; r < 9; r++) begin
            sel   = $urandom_range(0, 2);
            data  = int'($urandom_range(0, 255));
            pbit  = $urandom_range(0, 1) != 0;
            stopv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            case (sel)
                0:       send_frame(0, data, 8, 1'b0, 1'b0, 1, stopv, -1);
                1:       send_frame(1, data, 8, 1'b1, pbit, 1, stopv, -1);
                default: send_frame(2, data, 7, 1'b0, 1'b0, 2, stopv, -1);
            endcase
        end

        // Give dut2 a non-zero word so reset clearing is visible.
        send_frame(2, 32'h7F, 7, 1'b0, 1'b0, 2, 2'b11, -1);

        // Reset mid-frame on dut2, then 7-bit 2-stop 0x41.
        rx_line[2] = 1'b0;
        repeat (40) do_tick();
        check_eq("busy_before_rst", 32'(get_busy(2)), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals(2);
        check_reset_vals(0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_dout[i] = 32'd0;
            exp_ferr[i] = 1'b0;
            exp_perr[i] = 1'b0;
        end
        rx_line[2] = 1'b1;
        repeat (4) do_tick();
        check_reset_vals(2);
        send_frame(2, 32'h41, 7, 1'b0, 1'b0, 2, 2'b11, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #5000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_frame_seq.md
# uart_rx_frame_seq

Parametrised UART receive frame sequencer. It replaces the fixed 9-tick receive bit counter. It tracks a whole serial frame (start, data, optional parity, stop bits) on an oversampled baud tick, samples mid-bit, assembles the data word and flags framing and parity errors. It sits between the RX baud generator / input synchroniser and the receive controller, and hands the controller a one-cycle `done_rx` pulse per frame.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, default 16: `baud_tick_rx` pulses per bit period, even, legal 4..32.
- `PARITY_EN`, default 0: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN=0`.
- `STOP_BITS`, default 1: stop bits checked, 1 or 2.
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `en`, input, 1: enable from controller; low forces IDLE.
- `baud_tick_rx`, input, 1: oversample tick, one-cycle pulse.
- `rx_in`, input, 1: already-synchronised serial line, idle high.
- `busy`, output, 1: frame in progress (state not IDLE).
- `sample`, output, 1: one-cycle pulse per mid-bit sample taken (data, parity, stop).
- `bit_idx`, output, 4: index of the last sampled data bit (0..DATA_BITS-1).
- `data_out`, output, DATA_BITS: last received word, LSB first on line.
- `done_rx`, output, 1: one-cycle frame-complete pulse to controller.
- `frame_err`, output, 1: last frame had a low stop bit.
- `parity_err`, output, 1: last frame had a parity mismatch (0 if `PARITY_EN=0`).

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The tick counter `tcnt` is `$clog2(OVERSAMPLE)` bits wide. Counters advance only on cycles where `baud_tick_rx=1`.
- **IDLE:** on a tick with `rx_in=0`, set `tcnt<=0` and go to START.
- **START:** on each tick, `tcnt++`. On the tick where `tcnt==OVERSAMPLE/2-1`:
  - If `rx_in=1`, the start is false: return to IDLE with no other output change.
  - Otherwise set `tcnt<=0` and go to DATA.
- **DATA:** on the tick where `tcnt==OVERSAMPLE-1`, sample `rx_in` into the shift register (LSB first), pulse `sample`, set `tcnt<=0`, and update `bit_idx`. After the `DATA_BITS`-th sample, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** one bit period, sampled the same way. Parity error = XOR of the data bits, XOR `rx_in`, XOR `PARITY_ODD`, and must be non-zero. Go to STOP.
- **STOP:** `STOP_BITS` bit periods, sampled the same way. Any low stop sample sets a pending framing error. After the final stop sample:
  - load `data_out` from the shift register;
  - load `frame_err` and `parity_err` from the pending flags;
  - pulse `done_rx`;
  - go to IDLE.
- Error flags and `data_out` hold until the next completed frame. They are not sticky across frames.
- **`en` low in any state:** next state is IDLE; clear `tcnt`, bit count and pending flags. No `done_rx` or `sample` is produced, and `data_out` and the error flags are retained. Deasserting `en` has priority over a simultaneous tick.
- A frame with a framing error still completes and pulses `done_rx`. There is no break detection and no re-sync inside the frame.

## Timing
- Reset values: state IDLE; `busy=0`, `sample=0`, `bit_idx=0`, `data_out=0`, `done_rx=0`, `frame_err=0`, `parity_err=0`; all counters 0. Reset mid-frame aborts immediately with no pulse.
- All outputs are registered. `sample` and `done_rx` are high for exactly one `clk` cycle: the cycle after the sampling tick edge. `done_rx` coincides with the last stop `sample`.
- Bit-k data sample lands `OVERSAMPLE/2 + (k+1)*OVERSAMPLE` ticks after the falling-edge detection tick, i.e. mid-bit.
- Frame latency from detection tick to `done_rx`: `OVERSAMPLE/2 + (DATA_BITS+PARITY_EN+STOP_BITS)*OVERSAMPLE` ticks, plus 1 `clk`.
- `busy` rises the cycle after the detection tick and falls in the same cycle that `done_rx` rises.
- Back-to-back frames: a new start is detectable on the first tick after returning to IDLE.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 → exactly one `done_rx` pulse 152 ticks after detection; `data_out=0xA5`, both errors 0; 9 `sample` pulses.
- Low glitch of 4 ticks on an idle line → returns to IDLE after 8 ticks; no `sample`, no `done_rx`, outputs unchanged.
- 8N1, stop bit driven low, data 0x3C → `done_rx` pulses, `data_out=0x3C`, `frame_err=1`; next clean frame 0x00 clears `frame_err` to 0.
- `PARITY_EN=1`, even, data 0x07 sent with parity bit 0 → `parity_err=1`; resent with parity bit 1 → `parity_err=0`.
- `en` dropped during data bit 4 → IDLE next cycle; no `done_rx`, `data_out` keeps its previous value; a following frame 0x5A is received correctly.
- `rst` pulsed mid-frame, then a 7-bit, 2-stop frame (`DATA_BITS=7`, `STOP_BITS=2`) carrying 0x41 → all outputs at reset values during reset; afterwards `data_out=0x41`, with one `done_rx` after 8+9*16 ticks.
